taxi_axil_apb_adapter: RTL and testbench

Bridges an AXI4-Lite slave port (separate write and read interfaces) to an APB master port, the counterpart of the APB-to-AXI4-Lite adapter. Single outstanding transaction. Read/write arbitration is round-robin. When the AXI4-Lite data bus is wider than the APB data bus, each AXI4-Lite access is split into multiple APB transfers. Sits between an AXI4-Lite interconnect and a cluster of APB peripherals.

---
 rtl/taxi_axil_apb_adapter_pkg.sv | 11 +
 rtl/taxi_apb_if.sv | 38 +++
 rtl/taxi_axil_if.sv | 58 +++++
 rtl/taxi_axil_apb_adapter.sv | 216 +++++++++++++++++++++
 tb/tb_taxi_axil_apb_adapter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/taxi_axil_apb_adapter_pkg.sv
// Shared AXI4-Lite / APB definitions used by the AXI4-Lite to APB adapter.
package taxi_axil_apb_adapter_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    function automatic logic [1:0] axi_resp(input logic err);
        return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/taxi_apb_if.sv
// APB bundle (with strobes, protection and optional user sidebands).
interface taxi_apb_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int STRB_W    = DATA_W/8,
    parameter bit PAUSER_EN = 1'b0,
    parameter int PAUSER_W  = 1,
    parameter bit PWUSER_EN = 1'b0,
    parameter int PWUSER_W  = 1,
    parameter bit PRUSER_EN = 1'b0,
    parameter int PRUSER_W  = 1,
    parameter bit PBUSER_EN = 1'b0,
    parameter int PBUSER_W  = 1
) ();
    logic [ADDR_W-1:0]   paddr;
    logic [2:0]          pprot;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [STRB_W-1:0]   pstrb;
    logic                pready;
    logic [DATA_W-1:0]   prdata;
    logic                pslverr;
    logic [PAUSER_W-1:0] pauser;
    logic [PWUSER_W-1:0] pwuser;
    logic [PRUSER_W-1:0] pruser;
    logic [PBUSER_W-1:0] pbuser;

    modport mst (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
        input  pready, prdata, pslverr, pruser, pbuser
    );
    modport slv (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
        output pready, prdata, pslverr, pruser, pbuser
    );
endinterface

// File: rtl/taxi_axil_if.sv
// AXI4-Lite bundle with separate write (AW/W/B) and read (AR/R) modports.
interface taxi_axil_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int STRB_W    = DATA_W/8,
    parameter bit AWUSER_EN = 1'b0,
    parameter int AWUSER_W  = 1,
    parameter bit WUSER_EN  = 1'b0,
    parameter int WUSER_W   = 1,
    parameter bit BUSER_EN  = 1'b0,
    parameter int BUSER_W   = 1,
    parameter bit ARUSER_EN = 1'b0,
    parameter int ARUSER_W  = 1,
    parameter bit RUSER_EN  = 1'b0,
    parameter int RUSER_W   = 1
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic [AWUSER_W-1:0] awuser;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [STRB_W-1:0]   wstrb;
    logic [WUSER_W-1:0]  wuser;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic [BUSER_W-1:0]  buser;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic [ARUSER_W-1:0] aruser;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic [RUSER_W-1:0]  ruser;
    logic                rvalid;
    logic                rready;

    modport wr_slv (
        input  awaddr, awprot, awuser, awvalid, wdata, wstrb, wuser, wvalid, bready,
        output awready, wready, bresp, buser, bvalid
    );
    modport rd_slv (
        input  araddr, arprot, aruser, arvalid, rready,
        output arready, rdata, rresp, ruser, rvalid
    );
    modport wr_mst (
        output awaddr, awprot, awuser, awvalid, wdata, wstrb, wuser, wvalid, bready,
        input  awready, wready, bresp, buser, bvalid
    );
    modport rd_mst (
        output araddr, arprot, aruser, arvalid, rready,
        input  arready, rdata, rresp, ruser, rvalid
    );
endinterface

// File: rtl/taxi_axil_apb_adapter.sv
// AXI4-Lite slave to APB master bridge: one transaction in flight, round-robin
// read/write arbitration, wide AXI4-Lite accesses split into APB-width segments.
module taxi_axil_apb_adapter
    import taxi_axil_apb_adapter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    taxi_axil_if.wr_slv s_axil_wr,
    taxi_axil_if.rd_slv s_axil_rd,
    taxi_apb_if.mst     m_apb
);

    localparam int ADDR_W      = s_axil_wr.ADDR_W;
    localparam int AXIL_DATA_W = s_axil_wr.DATA_W;
    localparam int AXIL_STRB_W = s_axil_wr.STRB_W;
    localparam int APB_DATA_W  = m_apb.DATA_W;
    localparam int APB_STRB_W  = m_apb.STRB_W;
    localparam int SEG_CNT     = AXIL_DATA_W/APB_DATA_W;
    localparam int SEG_W       = SEG_CNT > 1 ? $clog2(SEG_CNT) : 1;

    localparam bit PAUSER_EN = m_apb.PAUSER_EN;
    localparam int PAUSER_W  = m_apb.PAUSER_W;
    localparam bit PWUSER_EN = m_apb.PWUSER_EN && s_axil_wr.WUSER_EN;
    localparam int PWUSER_W  = m_apb.PWUSER_W;
    localparam bit RUSER_EN  = m_apb.PRUSER_EN && s_axil_rd.RUSER_EN;
    localparam int RUSER_W   = s_axil_rd.RUSER_W;
    localparam bit BUSER_EN  = m_apb.PBUSER_EN && s_axil_wr.BUSER_EN;
    localparam int BUSER_W   = s_axil_wr.BUSER_W;

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(AXIL_STRB_W - 1);

    if (m_apb.ADDR_W != ADDR_W || s_axil_rd.ADDR_W != ADDR_W) begin : g_err_addr
        $fatal(1, "address width mismatch between AXI4-Lite and APB");
    end
    if (APB_DATA_W > AXIL_DATA_W || s_axil_rd.DATA_W != AXIL_DATA_W) begin : g_err_data
        $fatal(1, "APB data width must not exceed AXI4-Lite data width");
    end
    if (SEG_CNT != 1 && SEG_CNT != 2 && SEG_CNT != 4 && SEG_CNT != 8) begin : g_err_seg
        $fatal(1, "AXI4-Lite/APB width ratio must be 1, 2, 4 or 8");
    end
    if (AXIL_STRB_W != AXIL_DATA_W/8 || APB_STRB_W != APB_DATA_W/8) begin : g_err_strb
        $fatal(1, "strobe width must equal data width / 8");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

    state_t                  state;
    logic [SEG_W-1:0]        seg;
    logic                    is_wr;
    logic                    err;
    logic                    prefer_wr;
    logic [ADDR_W-1:0]       addr_r;
    logic [AXIL_DATA_W-1:0]  wdata_r;
    logic [AXIL_STRB_W-1:0]  wstrb_r;
    logic [AXIL_DATA_W-1:0]  rdata_r;
    logic [1:0]              bresp_r, rresp_r;
    logic [RUSER_W-1:0]      ruser_r;
    logic [BUSER_W-1:0]      buser_r;
    logic                    awready_r, wready_r, arready_r, bvalid_r, rvalid_r;
    logic                    psel_r, penable_r, pwrite_r;
    logic [ADDR_W-1:0]       paddr_r;
    logic [2:0]              pprot_r;
    logic [APB_DATA_W-1:0]   pwdata_r;
    logic [APB_STRB_W-1:0]   pstrb_r;
    logic [PAUSER_W-1:0]     pauser_r;
    logic [PWUSER_W-1:0]     pwuser_r;

    logic              wr_ok, rd_ok, last_seg;
    logic [SEG_W-1:0]  seg_nxt;
    logic [ADDR_W-1:0] aw_aligned, ar_aligned;

    assign wr_ok      = s_axil_wr.awvalid && s_axil_wr.wvalid;
    assign rd_ok      = s_axil_rd.arvalid;
    assign last_seg   = seg == SEG_W'(SEG_CNT - 1);
    assign seg_nxt    = seg + 1'b1;
    assign aw_aligned = s_axil_wr.awaddr & ~ADDR_MASK;
    assign ar_aligned = s_axil_rd.araddr & ~ADDR_MASK;

    // IDLE covers both the arbitration cycle and the one-cycle ready pulse;
    // request fields are latched on the edge that completes the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            seg       <= '0;
            is_wr     <= 1'b0;
            err       <= 1'b0;
            prefer_wr <= 1'b1;
            addr_r    <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            rdata_r   <= '0;
            bresp_r   <= AXI_RESP_OKAY;
            rresp_r   <= AXI_RESP_OKAY;
            ruser_r   <= '0;
            buser_r   <= '0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            arready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            rvalid_r  <= 1'b0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pprot_r   <= '0;
            pwdata_r  <= '0;
            pstrb_r   <= '0;
            pauser_r  <= '0;
            pwuser_r  <= '0;
        end else begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            arready_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (awready_r) begin
                        is_wr    <= 1'b1;
                        addr_r   <= aw_aligned;
                        wdata_r  <= s_axil_wr.wdata;
                        wstrb_r  <= s_axil_wr.wstrb;
                        psel_r   <= 1'b1;
                        pwrite_r <= 1'b1;
                        paddr_r  <= aw_aligned;
                        pprot_r  <= s_axil_wr.awprot;
                        pwdata_r <= s_axil_wr.wdata[APB_DATA_W-1:0];
                        pstrb_r  <= s_axil_wr.wstrb[APB_STRB_W-1:0];
                        pauser_r <= PAUSER_EN ? PAUSER_W'(s_axil_wr.awuser) : '0;
                        pwuser_r <= PWUSER_EN ? PWUSER_W'(s_axil_wr.wuser) : '0;
                        state    <= ST_SETUP;
                    end else if (arready_r) begin
                        is_wr    <= 1'b0;
                        addr_r   <= ar_aligned;
                        psel_r   <= 1'b1;
                        pwrite_r <= 1'b0;
                        paddr_r  <= ar_aligned;
                        pprot_r  <= s_axil_rd.arprot;
                        pwdata_r <= '0;
                        pstrb_r  <= '0;
                        pauser_r <= PAUSER_EN ? PAUSER_W'(s_axil_rd.aruser) : '0;
                        pwuser_r <= '0;
                        state    <= ST_SETUP;
                    end else if (wr_ok && (prefer_wr || !rd_ok)) begin
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                        prefer_wr <= 1'b0;
                    end else if (rd_ok) begin
                        arready_r <= 1'b1;
                        prefer_wr <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (m_apb.pready) begin
                        err <= err | m_apb.pslverr;
                        if (!is_wr) rdata_r[seg*APB_DATA_W +: APB_DATA_W] <= m_apb.prdata;
                        ruser_r <= RUSER_EN ? RUSER_W'(m_apb.pruser) : '0;
                        buser_r <= BUSER_EN ? BUSER_W'(m_apb.pbuser) : '0;
                        penable_r <= 1'b0;
                        if (last_seg) begin
                            psel_r <= 1'b0;
                            state  <= ST_RESP;
                            if (is_wr) begin
                                bvalid_r <= 1'b1;
                                bresp_r  <= axi_resp(err | m_apb.pslverr);
                            end else begin
                                rvalid_r <= 1'b1;
                                rresp_r  <= axi_resp(err | m_apb.pslverr);
                            end
                        end else begin
                            seg      <= seg_nxt;
                            paddr_r  <= addr_r + ADDR_W'(int'(seg_nxt) * APB_STRB_W);
                            pwdata_r <= is_wr ? wdata_r[int'(seg_nxt)*APB_DATA_W +: APB_DATA_W] : '0;
                            pstrb_r  <= is_wr ? wstrb_r[int'(seg_nxt)*APB_STRB_W +: APB_STRB_W] : '0;
                            state    <= ST_SETUP;
                        end
                    end
                end
                ST_RESP: begin
                    if ((bvalid_r && s_axil_wr.bready) || (rvalid_r && s_axil_rd.rready)) begin
                        bvalid_r <= 1'b0;
                        rvalid_r <= 1'b0;
                        err      <= 1'b0;
                        seg      <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign s_axil_wr.awready = awready_r;
    assign s_axil_wr.wready  = wready_r;
    assign s_axil_wr.bresp   = bresp_r;
    assign s_axil_wr.buser   = buser_r;
    assign s_axil_wr.bvalid  = bvalid_r;
    assign s_axil_rd.arready = arready_r;
    assign s_axil_rd.rdata   = rdata_r;
    assign s_axil_rd.rresp   = rresp_r;
    assign s_axil_rd.ruser   = ruser_r;
    assign s_axil_rd.rvalid  = rvalid_r;

    assign m_apb.psel    = psel_r;
    assign m_apb.penable = penable_r;
    assign m_apb.pwrite  = pwrite_r;
    assign m_apb.paddr   = paddr_r;
    assign m_apb.pprot   = pprot_r;
    assign m_apb.pwdata  = pwdata_r;
    assign m_apb.pstrb   = pstrb_r;
    assign m_apb.pauser  = pauser_r;
    assign m_apb.pwuser  = pwuser_r;

endmodule

// File: tb/tb_taxi_axil_apb_adapter.sv
// Scoreboard bench for the 64-bit AXI4-Lite to 32-bit APB adapter, with a
// word-addressed memory reference model and a wait-state/error APB responder.
module tb_taxi_axil_apb_adapter;
    import taxi_axil_apb_adapter_pkg::*;

    localparam int SEG = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    taxi_axil_if #(.DATA_W(64), .ADDR_W(16)) axil ();
    taxi_apb_if  #(.DATA_W(32), .ADDR_W(16)) apb ();

    taxi_axil_apb_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .s_axil_wr (axil),
        .s_axil_rd (axil),
        .m_apb     (apb)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } apb_xfer_t;

    typedef struct packed {
        logic [1:0]  resp;
        logic [63:0] data;
    } rsp_t;

    apb_xfer_t   exp_apb[$];
    rsp_t        exp_b[$];
    rsp_t        exp_r[$];
    logic [31:0] dev_mem[int];
    logic [31:0] ref_mem[int];
    bit          err_map[int];

    int n_chk = 0;
    int n_fail = 0;
    int force_wait = 0;
    int rdy_mode = 0;
    bit prefer_wr = 1'b1;
    bit alt_phase = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] dev_rd(input int a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic apb_xfer_t cur_apb();
        return '{apb.pwrite, apb.paddr, apb.pwdata, apb.pstrb, apb.pprot};
    endfunction

    // Reference model: 64-bit access at the 8-byte aligned address, two 32-bit words.
    task automatic model_write(input logic [15:0] addr, input logic [63:0] data,
                               input logic [7:0] strb, input logic [2:0] prot);
        int base = int'(addr) & ~7;
        bit e = 1'b0;
        if (alt_phase) chk("rr_order_wr", 64'(prefer_wr), 64'd1);
        prefer_wr = 1'b0;
        for (int k = 0; k < SEG; k++) begin
            int a = base + 4*k;
            logic [31:0] d = data[32*k +: 32];
            logic [3:0]  s = strb[4*k +: 4];
            logic [31:0] w;
            exp_apb.push_back('{1'b1, a[15:0], d, s, prot});
            if (err_map.exists(a)) e = 1'b1;
            else begin
                w = ref_rd(a);
                for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
                ref_mem[a] = w;
            end
        end
        exp_b.push_back('{e ? 2'b10 : 2'b00, 64'd0});
    endtask

    task automatic model_read(input logic [15:0] addr, input logic [2:0] prot);
        int base = int'(addr) & ~7;
        bit e = 1'b0;
        logic [63:0] d = '0;
        if (alt_phase) chk("rr_order_rd", 64'(prefer_wr), 64'd0);
        prefer_wr = 1'b1;
        for (int k = 0; k < SEG; k++) begin
            int a = base + 4*k;
            exp_apb.push_back('{1'b0, a[15:0], 32'd0, 4'd0, prot});
            d[32*k +: 32] = ref_rd(a);
            if (err_map.exists(a)) e = 1'b1;
        end
        exp_r.push_back('{e ? 2'b10 : 2'b00, d});
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input logic [2:0] prot);
        int t = 0;
        axil.awaddr = addr; axil.awprot = prot; axil.wdata = data; axil.wstrb = strb;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!axil.awready && t < 300);
        chk("aw_handshake", 64'(axil.awready), 64'd1);
        if (axil.awready) begin
            chk("wready_with_awready", 64'(axil.wready), 64'd1);
            model_write(addr, data, strb, prot);
            @(posedge clk); #1;
        end
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [2:0] prot);
        int t = 0;
        axil.araddr = addr; axil.arprot = prot; axil.arvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!axil.arready && t < 300);
        chk("ar_handshake", 64'(axil.arready), 64'd1);
        if (axil.arready) begin
            model_read(addr, prot);
            @(posedge clk); #1;
        end
        axil.arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_b.size() + exp_r.size() + exp_apb.size()) != 0 && t < 500) begin
            @(negedge clk); t++;
        end
        chk("drain", 64'(exp_b.size() + exp_r.size() + exp_apb.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        exp_apb.delete(); exp_b.delete(); exp_r.delete();
        prefer_wr = 1'b1;
        @(negedge clk);
        chk("rst_apb", {apb.psel, apb.penable, apb.pwrite}, 64'd0);
        chk("rst_axil", {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid}, 64'd0);
    endtask

    // APB responder: wait states, error map, memory; checks every completed transfer.
    initial begin : apb_slave
        bit in_acc;
        int wl;
        int a;
        apb_xfer_t snap, e;
        logic [31:0] w;
        in_acc = 1'b0; wl = 0; snap = '0;
        apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
        apb.pruser = '0; apb.pbuser = '0;
        forever begin
            @(posedge clk); #1;
            apb.pready = 1'b0; apb.pslverr = 1'b0;
            if (apb.psel && !apb.penable) begin
                snap = cur_apb();
                in_acc = 1'b0;
            end else if (apb.psel && apb.penable) begin
                chk("apb_stable", cur_apb(), snap);
                if (!in_acc) begin
                    in_acc = 1'b1;
                    wl = force_wait >= 0 ? force_wait : int'($urandom_range(0, 2));
                end
                if (wl == 0) begin
                    a = int'(apb.paddr);
                    apb.pready = 1'b1;
                    apb.pslverr = err_map.exists(a);
                    apb.prdata = apb.pwrite ? 32'h0 : dev_rd(a);
                    if (apb.pwrite && !err_map.exists(a)) begin
                        w = dev_rd(a);
                        for (int b = 0; b < 4; b++) if (apb.pstrb[b]) w[8*b +: 8] = apb.pwdata[8*b +: 8];
                        dev_mem[a] = w;
                    end
                    if (exp_apb.size() == 0) chk("apb_unexpected", 64'd1, 64'd0);
                    else begin
                        e = exp_apb.pop_front();
                        chk("apb_dir_addr_prot", {apb.pwrite, apb.paddr, apb.pprot}, {e.wr, e.addr, e.prot});
                        if (e.wr) chk("apb_wdata_strb", {apb.pwdata, apb.pstrb}, {e.data, e.strb});
                    end
                    in_acc = 1'b0;
                end else wl--;
            end else in_acc = 1'b0;
        end
    end

    // Response monitor
    always @(negedge clk) begin
        rsp_t e;
        if (!rst) begin
            if (axil.bvalid && axil.bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_b.pop_front();
                    chk("bresp", 64'(axil.bresp), 64'(e.resp));
                end
            end
            if (axil.rvalid && axil.rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_r.pop_front();
                    chk("rresp", 64'(axil.rresp), 64'(e.resp));
                    chk("rdata", axil.rdata, e.data);
                end
            end
            if (apb.psel) chk("no_overlap", 64'(axil.bvalid | axil.rvalid), 64'd0);
        end
    end

    initial begin : resp_ready
        axil.bready = 1'b1; axil.rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       begin axil.bready = 1'b1; axil.rready = 1'b1; end
                1:       begin axil.bready = ($urandom % 3) != 0; axil.rready = ($urandom % 3) != 0; end
                default: begin axil.bready = 1'b0; axil.rready = 1'b0; end
            endcase
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int first_bv;
        int t;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
        axil.awaddr = '0; axil.awprot = '0; axil.awuser = '0;
        axil.wdata = '0; axil.wstrb = '0; axil.wuser = '0;
        axil.araddr = '0; axil.arprot = '0; axil.aruser = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_apb", {apb.psel, apb.penable, apb.pwrite}, 64'd0);
        chk("reset_axil", {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid}, 64'd0);
        chk("reset_resp", {axil.bresp, axil.rresp}, 64'd0);
        chk("reset_rdata", axil.rdata, 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Split write with zero-wait APB and latency measurement from grant.
        force_wait = 0;
        do_write(16'h0100, 64'h11112222_33334444, 8'hF0, 3'b010);
        first_bv = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) chk("psel_grant_plus1", {apb.psel, apb.penable}, 64'b10);
            if (c == 2) chk("penable_grant_plus2", {apb.psel, apb.penable}, 64'b11);
            if (axil.bvalid && first_bv == 0) first_bv = c;
        end
        chk("bvalid_latency", 64'(first_bv), 64'(1 + 2*SEG));
        wait_idle();

        // Read with 3 wait states per segment.
        dev_mem[32'h2000] = 32'h12345678; ref_mem[32'h2000] = 32'h12345678;
        force_wait = 3;
        do_read(16'h2000, 3'b001);
        wait_idle();

        // Error on the first segment only.
        force_wait = 0;
        err_map[32'h108] = 1'b1;
        do_read(16'h0108, 3'b000);
        wait_idle();
        err_map.delete();

        // Randomized single transactions with backpressure, wait states and errors.
        force_wait = -1;
        rdy_mode = 1;
        for (int i = 0; i < 30; i++) begin
            logic [15:0] ad;
            ad = 16'($urandom_range(0, 63));
            err_map.delete();
            if ($urandom % 4 == 0) err_map[(int'(ad) & ~7) + 4*int'($urandom % 2)] = 1'b1;
            if ($urandom % 2)
                do_write(ad, {$urandom, $urandom}, 8'($urandom), 3'($urandom));
            else
                do_read(ad, 3'($urandom));
            wait_idle();
        end
        err_map.delete();

        // Write and read requests held continuously: grants must alternate.
        rdy_mode = 0;
        force_wait = 0;
        alt_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    do_write(16'h0200 + 16'(8*i), {$urandom, $urandom}, 8'($urandom), 3'd0);
            end
            begin
                for (int j = 0; j < 4; j++)
                    do_read(16'h0200 + 16'(8*j), 3'd0);
            end
        join
        wait_idle();
        alt_phase = 1'b0;

        // Reset during an APB access stalled by wait states.
        force_wait = 20;
        do_read(16'h0300, 3'd0);
        t = 0;
        while (!(apb.psel && apb.penable) && t < 50) begin @(negedge clk); t++; end
        chk("reached_access", 64'(apb.psel && apb.penable), 64'd1);
        apply_reset();

        // Reset while the read response is held by rready low.
        force_wait = 0;
        rdy_mode = 2;
        do_read(16'h0308, 3'd0);
        t = 0;
        while (!axil.rvalid && t < 50) begin @(negedge clk); t++; end
        chk("rvalid_pending", 64'(axil.rvalid), 64'd1);
        apply_reset();
        chk("rvalid_dropped", 64'(axil.rvalid), 64'd0);
        rdy_mode = 0;
        do_read(16'h0308, 3'd5);
        wait_idle();
        do_write(16'h030D, 64'hCAFEF00D_0BADBEEF, 8'h3C, 3'd6);
        do_read(16'h0308, 3'd0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
